// File: rtl/oms_seq_multiplier_if.sv
// Handshake and LUT-side bundle for the sequential OMS multiplier.
// The slave modport is the multiplier itself. The master modport is the
// environment, which supplies the operands and the LUT and consumes the product.
interface oms_seq_multiplier_if #(
   parameter int X_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [X_W-1:0]   x;
   logic [4:0]       a;
   logic [8:0]       lut_w;
   logic [4:0]       lut_a;
   logic [8:0]       lut_product;
   logic             out_valid;
   logic             out_ready;
   logic [X_W+4:0]   product;

   modport slave (
      input  in_valid, x, a, lut_product, out_ready,
      output in_ready, lut_w, lut_a, out_valid, product
   );

   modport master (
      output in_valid, x, a, lut_product, out_ready,
      input  in_ready, lut_w, lut_a, out_valid, product
   );
endinterface

// File: rtl/oms_seq_multiplier.sv
// Sequential multiplier in front of an odd-multiple-storage LUT.
// Each 4-bit nibble of x is written as u<<s with u odd. The LUT returns a*u,
// and that result is shifted back by s and by the nibble weight into the
// accumulator. A run takes one pass per nibble, and each pass takes one cycle.
module oms_seq_multiplier #(
   parameter int X_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   oms_seq_multiplier_if.slave   bus
);
   localparam int NP    = X_W / 4;
   localparam int P_W   = X_W + 5;
   localparam int IDX_W = (NP > 1) ? $clog2(NP) : 1;
   localparam int NIB_N = 2 ** IDX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg;
   logic [X_W-1:0]     x_reg;
   logic [P_W-1:0]     acc_reg;
   logic [P_W-1:0]     product_reg;
   logic               out_valid_reg;
   logic [8:0]         lut_w_reg;
   logic [4:0]         lut_a_reg;
   logic               run_reg;

   logic [3:0]         nib [NIB_N];
   logic [3:0]         cur_nib;
   logic [3:0]         next_nib;
   logic [IDX_W-1:0]   idx_inc;
   logic [1:0]         cur_s;
   logic               last_pass;
   logic               accept;
   logic [11:0]        term;
   logic [P_W-1:0]     contrib;
   logic [P_W-1:0]     acc_sum;

   // Count the trailing zeros of a nonzero nibble. A zero nibble never reaches this path.
   function automatic logic [1:0] tz_count(input logic [3:0] n);
      logic [1:0] s;
      if (n[0])      s = 2'd0;
      else if (n[1]) s = 2'd1;
      else if (n[2]) s = 2'd2;
      else           s = 2'd3;
      return s;
   endfunction

   // One-hot select of the odd part u at bit (u-1)/2. A zero nibble selects nothing.
   function automatic logic [8:0] odd_select(input logic [3:0] n);
      logic [3:0] u;
      logic [8:0] w;
      u = n >> tz_count(n);
      w = (n == 4'd0) ? 9'd0 : (9'd1 << u[3:1]);
      return w;
   endfunction

   // The nibble table is padded to a power of two, so idx_reg can index it at full width.
   genvar gi;
   generate
      for (gi = 0; gi < NIB_N; gi++) begin : g_nib
         if (gi < NP) begin : g_real
            assign nib[gi] = x_reg[4*gi +: 4];
         end else begin : g_pad
            assign nib[gi] = 4'd0;
         end
      end
   endgenerate

   assign idx_inc   = idx_reg + 1'b1;
   assign cur_nib   = nib[idx_reg];
   assign next_nib  = nib[idx_inc];
   assign cur_s     = tz_count(cur_nib);
   assign last_pass = (idx_reg == IDX_W'(NP - 1));
   assign accept    = bus.in_valid && bus.in_ready;

   // Restore a*n from a*u, then place the result at the nibble's weight.
   // A zero nibble contributes nothing, whatever the LUT returns.
   assign term    = {3'b000, bus.lut_product} << cur_s;
   assign contrib = (cur_nib == 4'd0) ? '0 : (P_W'(term) << {idx_reg, 2'b00});
   assign acc_sum = acc_reg + contrib;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = PASS;
         PASS:    if (last_pass) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode. in_ready stays low until the first clock after reset is released.
   always_comb begin
      bus.in_ready = (state_reg == IDLE) && run_reg;
   end

   // Mark the block as out of reset once the first clock edge has passed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) run_reg <= 1'b0;
      else          run_reg <= 1'b1;
   end

   // Datapath: latch the operands, feed the LUT one nibble per pass, accumulate, then publish the product.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_reg       <= '0;
         x_reg         <= '0;
         acc_reg       <= '0;
         product_reg   <= '0;
         out_valid_reg <= 1'b0;
         lut_w_reg     <= '0;
         lut_a_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  x_reg     <= bus.x;
                  acc_reg   <= '0;
                  idx_reg   <= '0;
                  lut_w_reg <= odd_select(bus.x[3:0]);
                  lut_a_reg <= bus.a;
               end
            end
            PASS: begin
               acc_reg <= acc_sum;
               if (!last_pass) begin
                  idx_reg   <= idx_inc;
                  lut_w_reg <= odd_select(next_nib);
               end else begin
                  product_reg   <= acc_sum;
                  out_valid_reg <= 1'b1;
                  lut_w_reg     <= '0;
               end
            end
            DONE: begin
               if (bus.out_ready) out_valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.lut_w     = lut_w_reg;
   assign bus.lut_a     = lut_a_reg;
   assign bus.product   = product_reg;
   assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_oms_seq_multiplier.sv
// Scoreboard testbench for oms_seq_multiplier. It runs an 8-bit instance and
// a 16-bit instance, each served by a behavioural odd-multiple LUT model.
module tb_oms_seq_multiplier;
   localparam int NP8  = 2;
   localparam int NP16 = 4;

   typedef struct {
      longint p;
      int     t;
      int     xv;
      int     av;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q8[$];
   exp_t q16[$];
   logic ov_prev8 = 1'b0;
   logic ov_prev16 = 1'b0;
   logic [8:0] garb8 = 9'd0;
   logic [8:0] garb16 = 9'd0;

   oms_seq_multiplier_if #(.X_W(8))  bus8 ();
   oms_seq_multiplier_if #(.X_W(16)) bus16 ();

   oms_seq_multiplier #(.X_W(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));
   oms_seq_multiplier #(.X_W(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      garb8  <= 9'($urandom);
      garb16 <= 9'($urandom);
   end

   // LUT model: returns a*u for the selected odd u, and garbage when nothing is selected.
   function automatic logic [8:0] lut_model(input logic [8:0] w, input logic [4:0] av,
                                            input logic [8:0] g);
      int r;
      r = int'(g);
      for (int k = 0; k < 8; k++) if (w[k]) r = int'(av) * (2 * k + 1);
      return r[8:0];
   endfunction

   // Expected LUT select for a nibble: remove the factors of two, then place a one at bit (u-1)/2.
   function automatic logic [8:0] ref_w(input int n);
      int u;
      if (n == 0) return 9'd0;
      u = n;
      while (u % 2 == 0) u = u / 2;
      return 9'(1 << ((u - 1) / 2));
   endfunction

   assign bus8.lut_product  = lut_model(bus8.lut_w,  bus8.lut_a,  garb8);
   assign bus16.lut_product = lut_model(bus16.lut_w, bus16.lut_a, garb16);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   // Monitor for the 8-bit instance: select legality, latency and product, against the scoreboard.
   always @(negedge clk) begin
      if (!reset_n) begin
         ov_prev8 = 1'b0;
      end else begin
         chk("lut_w8_legal", 64'($onehot0(bus8.lut_w) && !bus8.lut_w[8]), 64'd1);
         if (bus8.out_valid && !ov_prev8) begin
            if (q8.size() == 0) chk("unexpected_out8", 64'd1, 64'd0);
            else chk("latency8", 64'(cyc - q8[0].t), 64'(NP8));
         end
         if (bus8.out_valid && bus8.out_ready) begin
            if (q8.size() == 0) begin
               chk("empty_q8", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = q8.pop_front();
               chk("product8", 64'(bus8.product), 64'(e.p));
               $display("txn dut8  a=%0d x=0x%0h product=%0d expected=%0d",
                        e.av, e.xv, bus8.product, e.p);
            end
         end
         ov_prev8 = bus8.out_valid;
      end
   end

   // Monitor for the 16-bit instance.
   always @(negedge clk) begin
      if (!reset_n) begin
         ov_prev16 = 1'b0;
      end else begin
         chk("lut_w16_legal", 64'($onehot0(bus16.lut_w) && !bus16.lut_w[8]), 64'd1);
         if (bus16.out_valid && !ov_prev16) begin
            if (q16.size() == 0) chk("unexpected_out16", 64'd1, 64'd0);
            else chk("latency16", 64'(cyc - q16[0].t), 64'(NP16));
         end
         if (bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) begin
               chk("empty_q16", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = q16.pop_front();
               chk("product16", 64'(bus16.product), 64'(e.p));
               $display("txn dut16 a=%0d x=0x%0h product=%0d expected=%0d",
                        e.av, e.xv, bus16.product, e.p);
            end
         end
         ov_prev16 = bus16.out_valid;
      end
   end

   // Issue one operand pair to the 8-bit instance and check the LUT select on every pass.
   task automatic drv8(input logic [7:0] xv, input logic [4:0] av);
      bit got = 0;
      int n = 0;
      bus8.x = xv;
      bus8.a = av;
      bus8.in_valid = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         if (bus8.in_ready) begin
            got = 1;
            q8.push_back('{p: longint'(av) * longint'(xv), t: cyc + 1, xv: int'(xv), av: int'(av)});
         end
         n++;
      end
      if (!got) begin
         chk("accept_timeout8", 64'd0, 64'd1);
         bus8.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      for (int p = 0; p < NP8; p++) begin
         chk("lut_w8_pass", 64'(bus8.lut_w), 64'(ref_w(int'(xv[4*p +: 4]))));
         chk("lut_a8", 64'(bus8.lut_a), 64'(av));
         @(posedge clk); #1;
      end
      chk("lut_w8_end", 64'(bus8.lut_w), 64'd0);
   endtask

   // Issue one operand pair to the 16-bit instance.
   task automatic drv16(input logic [15:0] xv, input logic [4:0] av);
      bit got = 0;
      int n = 0;
      bus16.x = xv;
      bus16.a = av;
      bus16.in_valid = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         if (bus16.in_ready) begin
            got = 1;
            q16.push_back('{p: longint'(av) * longint'(xv), t: cyc + 1, xv: int'(xv), av: int'(av)});
         end
         n++;
      end
      if (!got) chk("accept_timeout16", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((q8.size() != 0 || q16.size() != 0) && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_done", 64'(q8.size() + q16.size()), 64'd0);
   endtask

   initial begin
      reset_n         = 1'b0;
      bus8.in_valid   = 1'b0;
      bus8.x          = '0;
      bus8.a          = '0;
      bus8.out_ready  = 1'b1;
      bus16.in_valid  = 1'b0;
      bus16.x         = '0;
      bus16.a         = '0;
      bus16.out_ready = 1'b1;

      // Reset state, held across clock edges.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus8.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
      chk("rst_lut_w", 64'(bus8.lut_w), 64'd0);
      chk("rst_lut_a", 64'(bus8.lut_a), 64'd0);
      chk("rst_product", 64'(bus8.product), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_rst", 64'(bus8.in_ready), 64'd1);

      // Directed cases from the test plan.
      drv8(8'hFF, 5'd31);
      drv8(8'h80, 5'd5);

      // Sweep x with a=7.
      for (int i = 0; i < 256; i++) drv8(8'(i), 5'd7);

      // a=0, then fully random operands.
      for (int i = 0; i < 4; i++) drv8(8'($urandom), 5'd0);
      for (int i = 0; i < 60; i++) drv8(8'($urandom), 5'($urandom));
      drain(20);

      // Backpressure: the product must hold while out_ready is low, and extra in_valid is ignored.
      bus8.out_ready = 1'b0;
      drv8(8'h36, 5'd9);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 64'(bus8.out_valid), 64'd1);
         chk("bp_product", 64'(bus8.product), 64'd486);
         chk("bp_in_ready", 64'(bus8.in_ready), 64'd0);
         bus8.x = 8'($urandom);
         bus8.a = 5'($urandom);
         bus8.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_released", 64'(bus8.out_valid), 64'd0);
      drain(10);

      // Reset during PASS aborts the run at once.
      bus8.x = 8'hFF;
      bus8.a = 5'd31;
      bus8.in_valid = 1'b1;
      @(negedge clk);
      chk("pre_rst_in_ready", 64'(bus8.in_ready), 64'd1);
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      chk("pre_rst_lut_w", 64'(bus8.lut_w), 64'h080);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_lut_w", 64'(bus8.lut_w), 64'd0);
      chk("arst_out_valid", 64'(bus8.out_valid), 64'd0);
      chk("arst_in_ready", 64'(bus8.in_ready), 64'd0);
      chk("arst_product", 64'(bus8.product), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 64'(bus8.in_ready), 64'd1);
      drv8(8'h01, 5'd3);

      // 16-bit instance.
      drv16(16'hFFFF, 5'd31);
      for (int i = 0; i < 20; i++) drv16(16'($urandom), 5'($urandom));
      drain(40);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/oms_seq_multiplier.md
# oms_seq_multiplier

Sequential multiplier controller that sits in front of the odd-multiple-storage (OMS) LUT and also consumes its output. It takes an unsigned multiplicand `x` and a 5-bit coefficient `a`, splits `x` into 4-bit nibbles, and for each nonzero nibble drives a one-hot odd-multiple select `lut_w` into the LUT. It then shifts the returned `lut_product` back by the nibble's trailing-zero count and nibble weight and accumulates the full product. It has valid/ready handshakes on both sides.

## Interface
- `X_W`, default 8: multiplicand width; legal values 4, 8, 12, 16. `NP = X_W/4` passes; `P_W = X_W+5` product width.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `x` in X_W: unsigned multiplicand.
- `a` in 5: unsigned coefficient.
- `lut_w` out 9: one-hot odd-multiple select to the LUT.
- `lut_a` out 5: coefficient to the LUT.
- `lut_product` in 9: LUT result, `a*u` for the selected odd `u`; combinational w.r.t. `lut_w`/`lut_a`.
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts the product.
- `product` out P_W: `a*x`.

## Operation
- States: IDLE, PASS, DONE. Pass index `idx` runs 0..NP-1.
- IDLE: `in_ready=1`. On `in_valid`:
  - latch `x` and `a`; clear the accumulator; set `idx=0`.
  - load `lut_w` and `lut_a` for nibble 0; go to PASS.
- Nibble decode, with `n = x[4*idx+3:4*idx]`:
  - `n=0`: `lut_w=9'b0`; contribution is 0 and `lut_product` is ignored.
  - `n≠0`: `n = u<<s`, where `u` is odd and `s` (0..3) is the trailing-zero count. `lut_w` is one-hot at bit `(u-1)/2`: u=1→bit0, 3→bit1 … 15→bit7. Bit 8 is never driven.
- PASS, each cycle:
  - `acc += (lut_product<<s) << (4*idx)`, or `+0` for a zero nibble.
  - `lut_product<<s` = `a*n` ≤ 465 and always fits 9 bits; `acc` is P_W wide and never overflows.
  - If `idx<NP-1`: increment `idx` and load `lut_w` for the next nibble.
  - Else: `product <= final acc`, `out_valid <= 1`, `lut_w <= 0`; go to DONE.
- DONE: hold `product` and `out_valid` until `out_ready=1`. Then `out_valid <= 0` and go to IDLE.
- `in_valid` outside IDLE is ignored. `x`/`a` changes after acceptance have no effect.
- `lut_w`, `lut_a`, `product`, `out_valid` are registered. `in_ready` is decoded from the state register.

## Timing
- Reset, asynchronous, all values held while `reset_n=0`: state=IDLE, `idx=0`, `acc=0`, `product=0`, `out_valid=0`, `lut_w=0`, `lut_a=0`, `in_ready=0`.
- `in_ready` goes to 1 from the first cycle after `reset_n` rises.
- Accept occurs at edge E0, when `in_valid && in_ready`. `lut_w`/`lut_a` are stable during the whole cycle following each load edge.
- `lut_product` is sampled at the next edge, so the LUT gets one full cycle of combinational path.
- `out_valid` rises after edge E0+NP. Latency is NP cycles (2 for X_W=8).
- With `out_ready` held high, `out_valid` lasts one cycle. The next accept is possible at E0+NP+2. Minimum initiation interval is NP+2.
- Reset mid-PASS or mid-DONE aborts the operation: no `out_valid`, and `lut_w` is immediately 0.
- Back-to-back: an `in_valid` in the same cycle `out_ready` completes DONE is not accepted. It is accepted in the following IDLE cycle.

## Test plan
- `a=31`, `x=8'hFF` → `lut_w` = 9'h080 then 9'h080; `product=7905` (13'h1EE1) with `out_valid` exactly 2 cycles after accept.
- `a=5`, `x=8'h80` → `lut_w` = 9'h000 (LUT fed garbage, ignored) then 9'h001 (u=1, s=3); `product=640`.
- Sweep `a=7`, `x` = 0..255 against a reference model; check every `lut_w` is one-hot or zero and never sets bit 8; `a=0` → `product=0`.
- Backpressure: `x=8'h36`, `a=9`, `out_ready=0` for 5 cycles → `out_valid` and `product=486` stable; `in_ready=0` throughout; extra `in_valid` ignored; completes after `out_ready=1`.
- Reset pulse in PASS → all outputs 0 asynchronously; after release, `in_ready=1` and a fresh `x=8'h01`, `a=3` gives `product=3`.
- X_W=16, `a=31`, `x=16'hFFFF` → 4 passes; `product=2031585`; `out_valid` 4 cycles after accept.
